div: RTL and testbench
======================

# div

Multi-cycle 32-bit signed/unsigned divider sequencer for the HI/LO datapath. ex raises start_i on DIV/DIVU and holds it until ready_o. The block runs a 32-iteration restoring shift-subtract under a four-state FSM and returns {remainder, quotient} for the HI/LO write. It also drives the pipeline stall request while a division is outstanding.

## Interface
- No parameters; data width fixed at 32 (`RegBus`).
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  in  32  dividend; sampled only when leaving DivFree
- opdata2_i  in  32  divisor; sampled only when leaving DivFree
- start_i  in  1  request; held high by ex until ready_o is seen
- annul_i  in  1  cancel (pipeline flush); aborts any in-flight division
- result_o  out  64  {remainder[31:0], quotient[31:0]}; HI = [63:32], LO = [31:0]
- ready_o  out  1  result_o valid
- stallreq_o  out  1  combinational: start_i & ~annul_i & ~ready_o

## Operation
- Reset (async): state = DivFree, cnt = 0, internal dividend and divisor = 0, result_o = 0, ready_o = 0.
- DivFree: if start_i & ~annul_i:
  - opdata2_i == 0 → DivByZero.
  - Otherwise → DivOn: cnt = 0, dividend = {32'b0, |op1|, 1'b0}, divisor = |op2|.
  - Absolute values apply only when signed_div_i and the operand MSB = 1; otherwise raw values are used.
  - Latch the sign flags: quotient negative = signed & (op1[31] ^ op2[31]); remainder negative = signed & op1[31].
  - Else stay in DivFree with ready_o = 0 and result_o = 0.
- DivByZero: → DivEnd, result = 0.
- DivOn:
  - annul_i = 1 → DivFree, cnt = 0, ready_o = 0, result_o = 0.
  - cnt < 32: tmp = {1'b0, dividend[63:32]} − {1'b0, divisor}, a 33-bit subtract.
    - tmp[32] = 1 → dividend = {dividend[63:0], 1'b0}.
    - Else → dividend = {tmp[31:0], dividend[31:0], 1'b1}.
    - cnt++.
  - cnt == 32: quotient = dividend[31:0] and remainder = dividend[64:33], each two's-complement negated per its latched flag. Load result_o, set ready_o = 1, → DivEnd, cnt = 0.
- DivEnd:
  - ready_o = 1 and result_o held.
  - start_i == 0 or annul_i == 1 → DivFree, ready_o = 0, result_o = 0.
- Operand inputs are ignored outside the DivFree → DivOn transition.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (natural wrap); no exception is raised.
- All arithmetic is modulo 2^32 per field; no saturation.

## Timing
- Edge E0 is the first edge sampling start_i & ~annul_i in DivFree.
- Normal division: E0 load; E1–E32 iterate (32 edges); E33 sign-fix and registered ready_o. ready_o is high in the cycle after E33, i.e. 34 edges after the request.
- Divide-by-zero: E0 → DivByZero, E1 → DivEnd; ready_o is high after E1.
- ready_o stays high until the edge after start_i falls. A start_i held high across DivEnd therefore does not launch a second division.
- stallreq_o is high from the cycle start_i rises, before E0, until ready_o rises. It drops in the same cycle ready_o rises.
- Annul in DivOn takes effect at the next edge. Annul together with a start in DivFree is ignored: stay in DivFree.
- rst asserted mid-operation returns all registers to reset values immediately, without waiting for clk.

## Structure
- defines.v holds the state codes DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11. It also holds DivResultReady/NotReady and DivStart/DivStop.
- Single flat module with no sub-modules; a 6-bit cnt.
- The integration edits to ex, which drives start/operands, muxes the result onto hi_o/lo_o and ORs stallreq, are out of scope for this block.

## Test plan
- DIVU 100 / 7 → ready_o 34 edges after start; result_o = {32'd2, 32'd14}; stallreq_o high throughout, then low.
- DIV 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE → quotient 0xFFFFFFFD, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}; DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Divisor 0 → ready_o after 2 edges with result_o = 0; start_i held 3 extra cycles → ready_o stays 1, no restart; drop start → DivFree.
- annul_i pulsed at iteration 10 → ready_o never asserts, state DivFree. A new DIVU 9 / 3 then returns {0, 3} in 34 edges.
- rst pulsed between clock edges at iteration 20 → outputs 0 immediately. A subsequent DIVU 50 / 5 → {0, 10}.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state codes, handshake levels and helpers for the
// multi-cycle HI/LO divider sequencer.
package div_pkg;

    localparam int RegBus = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Magnitude of an operand: negate only for signed ops with MSB set.
    function automatic logic [RegBus-1:0] abs_if(input logic sgn, input logic [RegBus-1:0] x);
        return (sgn && x[RegBus-1]) ? (~x + 1'b1) : x;
    endfunction

    // Conditional two's-complement negate, used for the final sign fix.
    function automatic logic [RegBus-1:0] neg_if(input logic neg, input logic [RegBus-1:0] x);
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div.sv
// div: 32-bit signed/unsigned restoring divider sequencer.
//   clk, rst         : clock, async active-high reset
//   signed_div_i     : 1 = DIV, 0 = DIVU
//   opdata1_i/2_i    : dividend / divisor, sampled when leaving DivFree
//   start_i          : request, held until ready_o
//   annul_i          : flush, aborts an in-flight division
//   result_o         : {remainder, quotient}; valid while ready_o
//   ready_o          : result valid (high while in DivEnd)
//   stallreq_o       : pipeline stall while a division is outstanding
module div
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [RegBus-1:0] opdata1_i,
    input  logic [RegBus-1:0] opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [63:0]       result_o,
    output logic              ready_o,
    output logic              stallreq_o
);

    div_state_t        r_state, w_next;
    logic [5:0]        r_cnt;
    logic [64:0]       r_dividend;
    logic [RegBus-1:0] r_divisor;
    logic              r_q_neg, r_r_neg;
    logic [63:0]       r_result;

    logic              w_go;
    logic              w_done;
    logic [RegBus:0]   w_tmp;

    assign w_go   = (start_i == DivStart) && !annul_i;
    assign w_done = (r_cnt == 6'd32);
    // 33-bit trial subtract; bit 32 set means the partial remainder is too small.
    assign w_tmp  = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

    assign stallreq_o = start_i & ~annul_i & ~ready_o;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= DivFree;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            DivFree:   if (w_go) w_next = (opdata2_i == '0) ? DivByZero : DivOn;
            DivByZero: w_next = DivEnd;
            DivOn: begin
                if (annul_i)     w_next = DivFree;
                else if (w_done) w_next = DivEnd;
            end
            DivEnd:    if (start_i == DivStop || annul_i) w_next = DivFree;
            default:   w_next = DivFree;
        endcase
    end

    // Outputs: ready and result are only exposed in DivEnd, so every exit
    // path (annul, reset, start drop) clears them without extra logic.
    always_comb begin
        ready_o  = DivResultNotReady;
        result_o = '0;
        if (r_state == DivEnd) begin
            ready_o  = DivResultReady;
            result_o = r_result;
        end
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                DivFree: begin
                    r_result <= '0;
                    if (w_go && opdata2_i != '0) begin
                        r_cnt      <= '0;
                        r_dividend <= {32'b0, abs_if(signed_div_i, opdata1_i), 1'b0};
                        r_divisor  <= abs_if(signed_div_i, opdata2_i);
                        r_q_neg    <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        r_r_neg    <= signed_div_i & opdata1_i[31];
                    end
                end
                DivByZero: r_result <= '0;
                DivOn: begin
                    if (annul_i) begin
                        r_cnt    <= '0;
                        r_result <= '0;
                    end else if (!w_done) begin
                        if (w_tmp[RegBus]) r_dividend <= {r_dividend[63:0], 1'b0};
                        else               r_dividend <= {w_tmp[31:0], r_dividend[31:0], 1'b1};
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        r_result <= {neg_if(r_r_neg, r_dividend[64:33]),
                                     neg_if(r_q_neg, r_dividend[31:0])};
                        r_cnt    <= '0;
                    end
                end
                DivEnd: if (start_i == DivStop || annul_i) r_result <= '0;
                default: r_result <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];
    logic        prev_ready = 1'b0;

    div dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with C-style truncation; the low 32
    // bits of each field give the architectural wrap for 0x80000000 / -1.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 0) return 64'd0;
        x = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        y = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: every rising ready_o must match the oldest expected result.
    always @(negedge clk) begin
        if (ready_o && !prev_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ready: got result %h expected no result", result_o);
            end else begin
                chk("result", result_o, exp_q.pop_front());
            end
        end
        prev_ready = ready_o;
    end

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
        int n;
        int lat;
        logic stall_ok;
        lat = (b == 0) ? 2 : 34;
        @(negedge clk);
        signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        exp_q.push_back(model(sgn, a, b));
        #1 stall_ok = stallreq_o;
        n = 0;
        while (n < 100) begin
            @(posedge clk); n++;
            #1;
            if (n == 1) begin
                opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = $urandom_range(0, 1);
            end
            if (ready_o) break;
            if (!stallreq_o) stall_ok = 1'b0;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("stall_during", {63'b0, stall_ok}, 64'd1);
        chk("stall_drop", {63'b0, stallreq_o}, 64'd0);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("ready_hold", {63'b0, ready_o}, 64'd1);
        end
        @(negedge clk); start_i = 1'b0;
        @(posedge clk); #1;
        chk("release", {result_o, 63'b0, ready_o}, 128'd0 >> 64);
    endtask

    initial begin
        int n;
        int seen;
        logic [31:0] a, b;
        #12;
        chk("reset_outs", {ready_o, stallreq_o, result_o[61:0]}, 64'd0);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 0);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 0);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, 0);
        run_div(1'b1, 32'h12345678, 32'd0, 3);

        // Annul at iteration 10: no result must appear.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk); annul_i = 1'b1;
        #1 chk("stall_annul", {63'b0, stallreq_o}, 64'd0);
        @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (ready_o) seen++; end
        chk("annul_no_ready", 64'(seen), 64'd0);
        run_div(1'b0, 32'd9, 32'd3, 0);

        // Async reset at iteration 20, between edges.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd0 + 32'd4; start_i = 1'b1;
        repeat (21) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("rst_async", {ready_o, result_o[62:0]}, 64'd0);
        start_i = 1'b0;
        #3 rst = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (ready_o) seen++; end
        chk("rst_no_ready", 64'(seen), 64'd0);
        run_div(1'b0, 32'd50, 32'd5, 0);

        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 16);
                2: b = -$urandom_range(1, 16);
                3: a = 32'h80000000;
                default: ;
            endcase
            run_div($urandom_range(0, 1), a, b, $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        n = exp_q.size();
        chk("queue_drained", 64'(n), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
